// File: rtl/dco_pkg.sv
// rtl/dco_pkg.sv - shared types, half-period table and decode for the DCO period meter
// No ports: provides meter_state_e, code_map_t, the legal half-period/code pairs and hp_to_code().
package dco_pkg;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } meter_state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] code;
  } code_map_t;

  // Half-periods (clk cycles between sig_in edges) produced by each DCO code.
  // The DCO toggles every period+1 cycles; its own table must agree with this one.
  localparam logic [7:0] HP_C80 = 8'd11;
  localparam logic [7:0] HP_C40 = 8'd10;
  localparam logic [7:0] HP_C20 = 8'd9;
  localparam logic [7:0] HP_C10 = 8'd8;
  localparam logic [7:0] HP_C08 = 8'd7;
  localparam logic [7:0] HP_C04 = 8'd6;
  localparam logic [7:0] HP_C02 = 8'd5;
  localparam logic [7:0] HP_C01 = 8'd4;
  localparam logic [7:0] HP_C00 = 8'd51;

  localparam logic [7:0] CODE_80 = 8'h80;
  localparam logic [7:0] CODE_40 = 8'h40;
  localparam logic [7:0] CODE_20 = 8'h20;
  localparam logic [7:0] CODE_10 = 8'h10;
  localparam logic [7:0] CODE_08 = 8'h08;
  localparam logic [7:0] CODE_04 = 8'h04;
  localparam logic [7:0] CODE_02 = 8'h02;
  localparam logic [7:0] CODE_01 = 8'h01;
  localparam logic [7:0] CODE_00 = 8'h00;

  // Illegal half-periods decode to an invalid map with code 0x00.
  function automatic code_map_t hp_to_code(input logic [7:0] hp);
    code_map_t m;
    m.valid = 1'b1;
    case (hp)
      HP_C80:  m.code = CODE_80;
      HP_C40:  m.code = CODE_40;
      HP_C20:  m.code = CODE_20;
      HP_C10:  m.code = CODE_10;
      HP_C08:  m.code = CODE_08;
      HP_C04:  m.code = CODE_04;
      HP_C02:  m.code = CODE_02;
      HP_C01:  m.code = CODE_01;
      HP_C00:  m.code = CODE_00;
      default: begin
        m.valid = 1'b0;
        m.code  = CODE_00;
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchroniser with a delay flop and any-edge detect
// Ports: clk, rst_n (sync, active-low), sig_in (async), sig_edge (high for one cycle per synchronised transition).
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  // Both flops are registered, so sig_edge has no combinational path from sig_in.
  assign sig_edge = sync_q[SYNC_STAGES-1] ^ dly_q;

endmodule

// File: rtl/dco_period_meter.sv
// rtl/dco_period_meter.sv - measures sig_in half-period, qualifies lock and recovers the DCO code
// Ports: clk, rst_n (sync, active-low), sig_in (async square wave),
//        half_period/meas_valid (last interval + update pulse), code/code_valid (recovered code),
//        locked (in LOCKED), timeout (one-cycle pulse on no-edge timeout).
module dco_period_meter
  import dco_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_in,
  output logic [7:0] half_period,
  output logic       meas_valid,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       locked,
  output logic       timeout
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] LOCK_N       = 4'(LOCK_COUNT);

  logic         sig_edge;
  meter_state_e state;
  logic [7:0]   cnt;
  logic [7:0]   ref_hp;
  logic [3:0]   match;
  logic [7:0]   cnt_inc;
  logic [3:0]   next_match;
  code_map_t    dec;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .sig_edge(sig_edge)
  );

  assign cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  // match==0 marks "no reference yet", so the first capture always starts a run of 1.
  assign next_match = (match != 4'd0 && half_period == ref_hp) ? match + 4'd1 : 4'd1;
  assign dec        = hp_to_code(half_period);

  // Capture happens on the edge cycle; the FSM then evaluates the registered
  // half_period while meas_valid is high, so locked/code follow one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SEEK;
      cnt         <= 8'd0;
      ref_hp      <= 8'd0;
      match       <= 4'd0;
      half_period <= 8'd0;
      meas_valid  <= 1'b0;
      code        <= 8'd0;
      code_valid  <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;

      if (sig_edge) begin
        // An edge always wins over a coincident timeout.
        cnt <= 8'd0;
        if (state == SEEK) begin
          state <= TRACK;
        end else begin
          half_period <= cnt_inc;
          meas_valid  <= 1'b1;
        end
      end else begin
        cnt <= cnt_inc;
        if (cnt == TIMEOUT_LAST) begin
          timeout    <= 1'b1;
          state      <= SEEK;
          match      <= 4'd0;
          locked     <= 1'b0;
          code_valid <= 1'b0;
        end
      end

      // meas_valid implies cnt was just cleared, so this never overlaps a timeout.
      if (meas_valid) begin
        case (state)
          TRACK: begin
            ref_hp <= half_period;
            match  <= next_match;
            if (next_match == LOCK_N) begin
              state      <= LOCKED;
              locked     <= 1'b1;
              code       <= dec.code;
              code_valid <= dec.valid;
            end
          end
          LOCKED: begin
            if (half_period != ref_hp) begin
              state      <= TRACK;
              ref_hp     <= half_period;
              match      <= 4'd1;
              locked     <= 1'b0;
              code_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dco_period_meter.sv
// tb/tb_dco_period_meter.sv - scoreboard bench for dco_period_meter
module tb_dco_period_meter;

  localparam int LOCK = 4;
  localparam int LAT  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig_in = 1'b0;
  logic [7:0] half_period;
  logic       meas_valid;
  logic [7:0] code;
  logic       code_valid;
  logic       locked;
  logic       timeout;

  dco_period_meter #(
    .SYNC_STAGES(2),
    .LOCK_COUNT (LOCK),
    .TIMEOUT    (255)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .half_period(half_period),
    .meas_valid (meas_valid),
    .code       (code),
    .code_valid (code_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         hp;
    int         at;
    logic       lk;
    logic [7:0] cd;
    logic       cv;
  } rec_t;

  rec_t exp_q[$];
  int   to_q[$];

  // Reference model: runs of equal half-periods, nothing about the RTL pipeline.
  bit         m_seek = 1'b1;
  int         m_ref = 0;
  int         m_run = 0;
  bit         m_locked = 1'b0;
  logic [7:0] m_code = 8'h00;
  bit         m_cv = 1'b0;
  int         m_last_toggle = 0;

  function automatic logic [8:0] ref_decode(input int hp);
    if (hp >= 4 && hp <= 11) return {1'b1, 8'(1 << (hp - 4))};
    if (hp == 51) return {1'b1, 8'h00};
    return {1'b0, 8'h00};
  endfunction

  task automatic model_edge(input int d);
    rec_t       r;
    logic [8:0] dc;
    m_last_toggle = cyc;
    if (m_seek) begin
      m_seek = 1'b0;
      return;
    end
    if (m_locked) begin
      if (d != m_ref) begin
        m_locked = 1'b0;
        m_cv     = 1'b0;
        m_ref    = d;
        m_run    = 1;
      end
    end else begin
      m_run = (m_run > 0 && d == m_ref) ? m_run + 1 : 1;
      m_ref = d;
      if (m_run == LOCK) begin
        dc       = ref_decode(d);
        m_locked = 1'b1;
        m_cv     = dc[8];
        m_code   = dc[7:0];
      end
    end
    r.hp = d;
    r.at = cyc + LAT;
    r.lk = m_locked;
    r.cd = m_code;
    r.cv = m_cv;
    exp_q.push_back(r);
  endtask

  task automatic model_reset();
    m_seek   = 1'b1;
    m_ref    = 0;
    m_run    = 0;
    m_locked = 1'b0;
    m_code   = 8'h00;
    m_cv     = 1'b0;
  endtask

  task automatic toggle_after(input int d);
    repeat (d) @(posedge clk);
    #1;
    sig_in = ~sig_in;
    model_edge(d);
  endtask

  task automatic toggles(input int d, input int n);
    for (int i = 0; i < n; i++) toggle_after(d);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_half_period"}, half_period, 0);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_code"}, code, 0);
    chk({tag, "_code_valid"}, code_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  // Monitor: pops on every meas_valid / timeout the DUT presents.
  bit   pend = 1'b0;
  rec_t pend_r;
  initial begin
    rec_t r;
    int   t;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("locked", locked, pend_r.lk);
        chk("code", code, pend_r.cd);
        chk("code_valid", code_valid, pend_r.cv);
        pend = 1'b0;
      end
      if (meas_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_meas_valid", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("half_period", half_period, r.hp);
          chk("meas_latency", cyc, r.at);
          pend_r = r;
          pend   = 1'b1;
        end
      end
      if (timeout) begin
        if (to_q.size() == 0) begin
          chk("unexpected_timeout", 1, 0);
        end else begin
          t = to_q.pop_front();
          chk("timeout_cycle", cyc, t);
          chk("timeout_locked", locked, 0);
          chk("timeout_code_valid", code_valid, 0);
        end
      end
    end
  end

  int vals[11] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 20, 51};

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Lock at 0x80: SEEK edge + 4 captures of 11, then hold for two more.
    toggle_after(4);
    toggles(11, 6);

    // Code change: lock at 4 (0x01), then move to 8 (0x10).
    toggles(4, 5);
    toggles(8, 5);

    // Default code and an illegal interval.
    toggles(51, 5);
    toggles(20, 5);

    // Jitter never locks.
    for (int i = 0; i < 5; i++) begin
      toggle_after(7);
      toggle_after(8);
    end

    // Randomised runs of repeated intervals.
    for (int i = 0; i < 15; i++) begin
      int v;
      int n;
      v = vals[$urandom_range(0, 10)];
      n = $urandom_range(1, 6);
      toggles(v, n);
    end

    // Timeout after lock.
    toggles(11, 5);
    to_q.push_back(m_last_toggle + LAT + 255);
    m_seek   = 1'b1;
    m_run    = 0;
    m_locked = 1'b0;
    m_cv     = 1'b0;
    repeat (300) @(posedge clk);

    // Reset in TRACK: SEEK edge + 2 captures, then 1-cycle reset.
    toggle_after(3);
    toggles(9, 2);
    repeat (6) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    @(posedge clk);
    #1;
    check_outputs_zero("mid_reset");
    rst_n = 1'b1;
    model_reset();
    toggle_after(5);
    toggles(9, 5);

    repeat (10) @(posedge clk);
    #1;
    chk("meas_queue_drained", exp_q.size(), 0);
    chk("timeout_queue_drained", to_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
